// File: rtl/collector_input_arbiter.sv
// collector_input_arbiter
//
// Round-robin front end for packet_collector. Each ejection port writes flits
// into its own small FIFO. Every cycle one queued flit is forwarded to the
// collector. When nothing is queued and the sink can accept, an all-zero
// drain beat is sent instead, so that completed packets keep leaving the
// collector.
//
// Optional build macro: ARB_STATS_EN adds per-port saturating grant counters
// and a saturating drain-beat counter.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_valid     per-port flit valid
//   in_flit      per-port flit, port p at [p*FLIT_W +: FLIT_W]
//   in_ready     per-port FIFO not full (registered)
//   drain_en     permits drain beats
//   sink_ready   sink will take a collector valid_out two cycles later
//   out_valid    collector valid_in
//   out_ce       collector ce, same as out_valid
//   out_flit     collector input_data
//   out_send     collector send_signal, registered copy of sink_ready
//   grant_port   port whose flit is on out_flit (0 for drain/idle)
//   grant_count  (ARB_STATS_EN) NUM_PORTS x 16-bit grant counters
//   drain_count  (ARB_STATS_EN) 16-bit drain-beat counter
//
// state   | meaning
// S_IDLE  | no beat on the output; out_flit holds its last value
// S_FLIT  | a popped flit is on out_flit
// S_DRAIN | an all-zero drain beat is on out_flit

module collector_input_arbiter #(
   parameter int NUM_PORTS       = 4,
   parameter int NODE_COUNT      = 8,
   parameter int PACKET_ID_WIDTH = 5,
   parameter int FIFO_DEPTH      = 4,
   localparam int NODE_W = $clog2(NODE_COUNT),
   localparam int FLIT_W = 1 + 2*NODE_W + PACKET_ID_WIDTH + 17 + 2,
   localparam int PORT_W = $clog2(NUM_PORTS)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        in_valid,
   input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
   output logic [NUM_PORTS-1:0]        in_ready,
   input  logic                        drain_en,
   input  logic                        sink_ready,
   output logic                        out_valid,
   output logic                        out_ce,
   output logic [FLIT_W-1:0]           out_flit,
   output logic                        out_send,
`ifdef ARB_STATS_EN
   output logic [NUM_PORTS*16-1:0]     grant_count,
   output logic [15:0]                 drain_count,
`endif
   output logic [PORT_W-1:0]           grant_port
);

   localparam int ADDR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FLIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t state, state_next;

   logic [FLIT_W-1:0] mem [NUM_PORTS][FIFO_DEPTH];
   logic [ADDR_W-1:0] wr_ptr [NUM_PORTS];
   logic [ADDR_W-1:0] rd_ptr [NUM_PORTS];
   logic [CNT_W-1:0]  count [NUM_PORTS];
   logic [CNT_W-1:0]  count_next [NUM_PORTS];

   logic [NUM_PORTS-1:0] push;
   logic [NUM_PORTS-1:0] pop;
   logic [NUM_PORTS-1:0] nonempty;
   logic [PORT_W-1:0]    rr_ptr;
   logic [PORT_W-1:0]    pick;
   logic [PORT_W-1:0]    cand;
   logic                 found;

   // FIFO occupancy bookkeeping
   always_comb begin
      push     = in_valid & in_ready;
      nonempty = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         nonempty[p]   = (count[p] != '0);
         count_next[p] = count[p] + CNT_W'(push[p]) - CNT_W'(pop[p]);
      end
   end

   // First non-empty port at or after rr_ptr, wrapping around
   always_comb begin
      found = 1'b0;
      pick  = '0;
      cand  = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = PORT_W'((int'(rr_ptr) + i) % NUM_PORTS);
         if (!found && nonempty[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   // Next-state: flits always beat drain beats
   always_comb begin
      state_next = S_IDLE;
      pop        = '0;
      if (found) begin
         state_next = S_FLIT;
         pop[pick]  = 1'b1;
      end else if (drain_en && sink_ready) begin
         state_next = S_DRAIN;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_next;
   end

   assign out_valid = (state != S_IDLE);
   assign out_ce    = out_valid;

   // Output datapath and round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_flit   <= '0;
         grant_port <= '0;
         out_send   <= 1'b0;
         rr_ptr     <= '0;
      end else begin
         out_send <= sink_ready;
         case (state_next)
            S_FLIT: begin
               out_flit   <= mem[pick][rd_ptr[pick]];
               grant_port <= pick;
               rr_ptr     <= (pick == PORT_W'(NUM_PORTS - 1)) ? '0 : pick + PORT_W'(1);
            end
            S_DRAIN: begin
               out_flit   <= '0;
               grant_port <= '0;
            end
            default: begin
               grant_port <= '0;
            end
         endcase
      end
   end

   // FIFO pointers, counts and registered ready
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            wr_ptr[p] <= '0;
            rd_ptr[p] <= '0;
            count[p]  <= '0;
         end
         in_ready <= '1;
      end else begin
         for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) wr_ptr[p] <= wr_ptr[p] + ADDR_W'(1);
            if (pop[p])  rd_ptr[p] <= rd_ptr[p] + ADDR_W'(1);
            count[p]    <= count_next[p];
            in_ready[p] <= (count_next[p] < CNT_W'(FIFO_DEPTH));
         end
      end
   end

   // Storage needs no reset: contents are only visible through count
   always_ff @(posedge clk) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (push[p]) mem[p][wr_ptr[p]] <= in_flit[p*FLIT_W +: FLIT_W];
      end
   end

`ifdef ARB_STATS_EN
   logic [15:0] gcnt [NUM_PORTS];
   logic [15:0] dcnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int p = 0; p < NUM_PORTS; p++) gcnt[p] <= '0;
         dcnt <= '0;
      end else begin
         if (state_next == S_FLIT && gcnt[pick] != 16'hFFFF)
            gcnt[pick] <= gcnt[pick] + 16'd1;
         if (state_next == S_DRAIN && dcnt != 16'hFFFF)
            dcnt <= dcnt + 16'd1;
      end
   end

   for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stats
      assign grant_count[g*16 +: 16] = gcnt[g];
   end
   assign drain_count = dcnt;
`endif

endmodule

// File: tb/tb_collector_input_arbiter.sv
// Directed bench for collector_input_arbiter with default parameters
// (4 ports, 31-bit flits, FIFO depth 4). Inputs change 1 time unit after a
// rising edge and outputs are sampled at the same point.

module tb_collector_input_arbiter;

   localparam int NP = 4;
   localparam int FW = 31;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NP-1:0]  in_valid;
   logic [NP*FW-1:0] in_flit;
   logic [NP-1:0]  in_ready;
   logic           drain_en;
   logic           sink_ready;
   logic           out_valid;
   logic           out_ce;
   logic [FW-1:0]  out_flit;
   logic           out_send;
   logic [1:0]     grant_port;
`ifdef ARB_STATS_EN
   logic [NP*16-1:0] grant_count;
   logic [15:0]      drain_count;
`endif

   int total = 0;
   int bad   = 0;

   collector_input_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_flit    (in_flit),
      .in_ready   (in_ready),
      .drain_en   (drain_en),
      .sink_ready (sink_ready),
      .out_valid  (out_valid),
      .out_ce     (out_ce),
      .out_flit   (out_flit),
      .out_send   (out_send),
`ifdef ARB_STATS_EN
      .grant_count(grant_count),
      .drain_count(drain_count),
`endif
      .grant_port (grant_port)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      in_valid   = '0;
      in_flit    = '0;
      drain_en   = 1'b0;
      sink_ready = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
      total++; if (out_ce !== 1'b0) begin bad++; $display("FAIL reset_out_ce got %b want 0", out_ce); end
      total++; if (out_send !== 1'b0) begin bad++; $display("FAIL reset_out_send got %b want 0", out_send); end
      total++; if (out_flit !== 31'h0) begin bad++; $display("FAIL reset_out_flit got %h want 0", out_flit); end
      total++; if (grant_port !== 2'd0) begin bad++; $display("FAIL reset_grant got %0d want 0", grant_port); end
      total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL reset_in_ready got %b want 1111", in_ready); end
   endtask

   task automatic test_single_port();
      apply_reset();
      in_valid = 4'b0100;
      in_flit[2*FW +: FW] = 31'h4000_1235;
      step();
      in_valid = '0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_no_bypass got %b want 0", out_valid); end
      step();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", out_valid); end
      total++; if (out_ce !== 1'b1) begin bad++; $display("FAIL single_ce got %b want 1", out_ce); end
      total++; if (out_flit !== 31'h4000_1235) begin bad++; $display("FAIL single_flit got %h want 40001235", out_flit); end
      total++; if (grant_port !== 2'd2) begin bad++; $display("FAIL single_grant got %0d want 2", grant_port); end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL single_after got %b want 0", out_valid); end
      total++; if (out_flit !== 31'h4000_1235) begin bad++; $display("FAIL single_hold got %h want 40001235", out_flit); end
      total++; if (grant_port !== 2'd0) begin bad++; $display("FAIL single_idle_grant got %0d want 0", grant_port); end
   endtask

   task automatic test_round_robin();
      logic [FW-1:0] obs_f [12];
      logic [1:0]    obs_g [12];
      logic          obs_v [12];
      logic [FW-1:0] exp_f;
      apply_reset();
      for (int e = 1; e <= 13; e++) begin
         if (e <= 3) begin
            for (int p = 0; p < NP; p++) in_flit[p*FW +: FW] = 31'h4000_0000 + 31'(p*16 + e - 1);
            in_valid = 4'b1111;
         end else begin
            in_valid = '0;
         end
         step();
         if (e >= 2) begin
            obs_v[e-2] = out_valid;
            obs_g[e-2] = grant_port;
            obs_f[e-2] = out_flit;
         end
      end
      for (int i = 0; i < 12; i++) begin
         exp_f = 31'h4000_0000 + 31'((i % 4)*16 + i / 4);
         total++; if (obs_v[i] !== 1'b1) begin bad++; $display("FAIL rr_valid[%0d] got %b want 1", i, obs_v[i]); end
         total++; if (obs_g[i] !== 2'(i % 4)) begin bad++; $display("FAIL rr_grant[%0d] got %0d want %0d", i, obs_g[i], i % 4); end
         total++; if (obs_f[i] !== exp_f) begin bad++; $display("FAIL rr_flit[%0d] got %h want %h", i, obs_f[i], exp_f); end
      end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rr_end_valid got %b want 0", out_valid); end
      total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL rr_in_ready got %b want 1111", in_ready); end
   endtask

   task automatic test_back_to_back();
      int a_idx;
      logic [FW-1:0] exp_f;
      apply_reset();
      // one grant to port 1 moves the pointer to port 2 before the burst
      in_valid = 4'b0010;
      in_flit[1*FW +: FW] = 31'h4200_0001;
      step();
      for (int e = 2; e <= 7; e++) begin
         in_valid = 4'b1111;
         in_flit[0*FW +: FW] = 31'h4000_0000 + 31'(e);
         in_flit[1*FW +: FW] = 31'h4100_0010 + 31'((e <= 6) ? e - 2 : 4);
         in_flit[2*FW +: FW] = 31'h4020_0000 + 31'(e);
         in_flit[3*FW +: FW] = 31'h4030_0000 + 31'(e);
         step();
         if (e == 2) begin
            total++; if (grant_port !== 2'd1 || out_flit !== 31'h4200_0001) begin bad++; $display("FAIL b2b_pre got port %0d flit %h want port 1 flit 42000001", grant_port, out_flit); end
         end
         if (e == 5) begin
            total++; if (in_ready !== 4'b1101) begin bad++; $display("FAIL b2b_full got %b want 1101", in_ready); end
         end
         if (e == 6) begin
            total++; if (in_ready !== 4'b0010) begin bad++; $display("FAIL b2b_freed got %b want 0010", in_ready); end
            total++; if (grant_port !== 2'd1 || out_flit !== 31'h4100_0010) begin bad++; $display("FAIL b2b_a0 got port %0d flit %h want port 1 flit 41000010", grant_port, out_flit); end
         end
         if (e == 7) begin
            total++; if (in_ready !== 4'b0100) begin bad++; $display("FAIL b2b_refull got %b want 0100", in_ready); end
            total++; if (grant_port !== 2'd2) begin bad++; $display("FAIL b2b_g7 got %0d want 2", grant_port); end
         end
      end
      in_valid = '0;
      a_idx = 1;
      for (int j = 0; j < 15; j++) begin
         step();
         total++; if (out_valid !== 1'b1 || grant_port !== 2'((j + 3) % 4)) begin bad++; $display("FAIL b2b_drain[%0d] got valid %b port %0d want valid 1 port %0d", j, out_valid, grant_port, (j + 3) % 4); end
         if ((j + 3) % 4 == 1) begin
            exp_f = 31'h4100_0010 + 31'(a_idx);
            total++; if (out_flit !== exp_f) begin bad++; $display("FAIL b2b_order[%0d] got %h want %h", a_idx, out_flit, exp_f); end
            a_idx++;
         end
      end
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_empty got %b want 0", out_valid); end
   endtask

   task automatic test_drain();
      apply_reset();
      in_valid = 4'b0100;
      in_flit[2*FW +: FW] = 31'h4000_0777;
      step();
      in_valid = '0;
      drain_en = 1'b1;
      sink_ready = 1'b1;
      step();
      total++; if (grant_port !== 2'd2 || out_flit !== 31'h4000_0777) begin bad++; $display("FAIL drain_pre got port %0d flit %h want port 2 flit 40000777", grant_port, out_flit); end
      for (int i = 0; i < 3; i++) begin
         step();
         total++; if (out_valid !== 1'b1 || out_ce !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got %b want 1", i, out_valid); end
         total++; if (out_flit !== 31'h0) begin bad++; $display("FAIL drain_flit[%0d] got %h want 0", i, out_flit); end
         total++; if (out_send !== 1'b1) begin bad++; $display("FAIL drain_send[%0d] got %b want 1", i, out_send); end
         total++; if (grant_port !== 2'd0) begin bad++; $display("FAIL drain_grant[%0d] got %0d want 0", i, grant_port); end
      end
      drain_en = 1'b0;
      step();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL nodrain_valid got %b want 0", out_valid); end
      total++; if (out_send !== 1'b1) begin bad++; $display("FAIL nodrain_send got %b want 1", out_send); end
      in_valid = 4'b1001;
      in_flit[0*FW +: FW] = 31'h4000_0A00;
      in_flit[3*FW +: FW] = 31'h4000_0A03;
      sink_ready = 1'b0;
      step();
      total++; if (out_valid !== 1'b0 || out_send !== 1'b0) begin bad++; $display("FAIL idle_send got valid %b send %b want 0 0", out_valid, out_send); end
      in_valid = '0;
      drain_en = 1'b1;
      sink_ready = 1'b1;
      step();
      total++; if (grant_port !== 2'd3 || out_flit !== 31'h4000_0A03) begin bad++; $display("FAIL rr_kept got port %0d flit %h want port 3 flit 40000a03", grant_port, out_flit); end
      total++; if (out_send !== 1'b1) begin bad++; $display("FAIL flit_send got %b want 1", out_send); end
      step();
      total++; if (grant_port !== 2'd0 || out_flit !== 31'h4000_0A00) begin bad++; $display("FAIL flit_over_drain got port %0d flit %h want port 0 flit 40000a00", grant_port, out_flit); end
      step();
      total++; if (out_valid !== 1'b1 || out_flit !== 31'h0) begin bad++; $display("FAIL drain_after got valid %b flit %h want 1 0", out_valid, out_flit); end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      in_valid = 4'b0111;
      in_flit[0*FW +: FW] = 31'h4000_0B00;
      in_flit[1*FW +: FW] = 31'h4000_0B01;
      in_flit[2*FW +: FW] = 31'h4000_0B02;
      sink_ready = 1'b1;
      step();
      in_valid = '0;
      step();
      total++; if (out_valid !== 1'b1 || grant_port !== 2'd0) begin bad++; $display("FAIL mid_pre got valid %b port %0d want 1 0", out_valid, grant_port); end
      #2;
      rst_n = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || out_ce !== 1'b0 || out_send !== 1'b0) begin bad++; $display("FAIL mid_ctrl got valid %b ce %b send %b want 0 0 0", out_valid, out_ce, out_send); end
      total++; if (out_flit !== 31'h0 || grant_port !== 2'd0) begin bad++; $display("FAIL mid_data got flit %h port %0d want 0 0", out_flit, grant_port); end
      total++; if (in_ready !== 4'b1111) begin bad++; $display("FAIL mid_ready got %b want 1111", in_ready); end
      sink_ready = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_quiet[%0d] got %b want 0", i, out_valid); end
      end
      in_valid = 4'b1000;
      in_flit[3*FW +: FW] = 31'h4000_0B03;
      step();
      in_valid = '0;
      step();
      total++; if (out_valid !== 1'b1 || grant_port !== 2'd3 || out_flit !== 31'h4000_0B03) begin bad++; $display("FAIL mid_new got valid %b port %0d flit %h want 1 3 40000b03", out_valid, grant_port, out_flit); end
   endtask

`ifdef ARB_STATS_EN
   task automatic test_stats();
      apply_reset();
      in_valid = 4'b0001;
      in_flit[0*FW +: FW] = 31'h4000_0C00;
      for (int i = 0; i < 70002; i++) step();
      in_valid = '0;
      step();
      total++; if (grant_count[15:0] !== 16'hFFFF) begin bad++; $display("FAIL stats_sat got %h want ffff", grant_count[15:0]); end
      total++; if (grant_count[31:16] !== 16'h0) begin bad++; $display("FAIL stats_p1 got %h want 0", grant_count[31:16]); end
      drain_en = 1'b1;
      sink_ready = 1'b1;
      for (int i = 0; i < 3; i++) step();
      drain_en = 1'b0;
      step();
      total++; if (drain_count !== 16'd3) begin bad++; $display("FAIL stats_drain got %0d want 3", drain_count); end
   endtask
`endif

   initial begin
      test_reset();
      test_single_port();
      test_round_robin();
      test_back_to_back();
      test_drain();
      test_reset_mid();
`ifdef ARB_STATS_EN
      test_stats();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/collector_input_arbiter.md
# collector_input_arbiter

Round-robin front end for `packet_collector`. It merges flit streams from NUM_PORTS router ejection ports into the collector's single `valid_in`/`input_data` path, buffering each port in a small FIFO. It also generates `send_signal` from a downstream sink-ready handshake. When no flits are pending and the sink can accept, it inserts empty "drain beats" so completed packets still leave the collector.

## Interface
- NUM_PORTS, 4: requesting ejection ports (2..8)
- NODE_COUNT, 8: node count; NODE_W = $clog2(NODE_COUNT)
- PACKET_ID_WIDTH, 5: packet ID width
- FIFO_DEPTH, 4: per-port FIFO entries (power of 2, ≥2)
- FLIT_W, derived: 1 + 2*NODE_W + PACKET_ID_WIDTH + 17 + 2 (31 with defaults); bit FLIT_W-1 is the flit valid bit
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  NUM_PORTS  per-port flit valid
- in_flit  in  NUM_PORTS×FLIT_W  per-port flit, same packing as collector `input_data`
- in_ready  out  NUM_PORTS  per-port FIFO not full (registered)
- drain_en  in  1  permits drain beats
- sink_ready  in  1  sink guarantees it accepts a collector `valid_out` in the cycle after next
- out_valid  out  1  to collector `valid_in`
- out_ce  out  1  to collector `ce`; equals out_valid
- out_flit  out  FLIT_W  to collector `input_data`
- out_send  out  1  to collector `send_signal`
- grant_port  out  $clog2(NUM_PORTS)  index of the port whose flit is on out_flit (0 on drain/idle)

## Operation
- Push: a flit is written into FIFO p at the edge where in_valid[p] && in_ready[p]. If in_ready[p] is 0, the flit is ignored.
- in_ready[p] is registered and equals (count_p < FIFO_DEPTH) after the edge's push/pop. A pop and push to a full FIFO on the same edge is impossible because in_ready was 0.
- Output FSM, evaluated every edge in priority order:
  - FLIT: at least one FIFO is non-empty. Grant the first non-empty port at or after rr_ptr (wrapping). Pop its head into out_flit and set rr_ptr = grant+1 mod NUM_PORTS.
  - DRAIN: all FIFOs are empty and drain_en && sink_ready. out_flit = all zeros (valid bit 0) and out_valid = 1.
  - IDLE: otherwise. out_valid = 0 and out_flit holds its last value.
- out_send is registered to sink_ready sampled on the same edge, in any state. It has effect only when out_valid = 1.
- rr_ptr advances only on FLIT grants. DRAIN and IDLE leave it unchanged.
- Flits within one port are never reordered. Fairness is strict round-robin: while all ports stay non-empty, each port gets at most one grant per NUM_PORTS FLIT cycles.

## Timing
- Reset values: out_valid = 0, out_ce = 0, out_send = 0, out_flit = 0, grant_port = 0, in_ready = all 1, every FIFO empty, rr_ptr = 0.
- Latency: a flit accepted at edge k drives out_valid at edge k+1 at the earliest. There is no same-cycle bypass.
- Throughput: one flit (or one drain beat) per cycle.
- Reset mid-operation: FIFO contents are discarded immediately (asynchronous), and all outputs return to reset values.
- Simultaneous grant-eligible ports plus sink_ready: the flit always wins over a drain beat, and out_send is still asserted alongside it.
- drain_en deasserted: no drain beats are generated. out_send is still driven from sink_ready.

## Configuration
- ARB_STATS_EN defined: adds output `grant_count` (NUM_PORTS×16), one saturating counter per port incremented on each FLIT grant to that port, plus output `drain_count` (16), saturating, counting drain beats. All counters reset to 0.
- ARB_STATS_EN undefined: these ports and counters are absent, and all other behaviour is identical.

## Test plan
- Single port: in_flit[2] = 31'h4000_1235 pushed at edge 1 → out_valid = 1, out_flit = 31'h4000_1235, grant_port = 2 after edge 2; out_valid = 0 after edge 3.
- All 4 ports push 3 flits each simultaneously → grants are 0,1,2,3 repeated 3 times over 12 consecutive cycles, with per-port order preserved.
- Port 1 receives 5 back-to-back flits with FIFO_DEPTH = 4 and ports 0, 2, 3 kept busy → in_ready[1] = 0 once 4 flits are held, and the 5th flit is accepted only after the pop that frees a slot.
- All FIFOs empty, drain_en = 1, sink_ready = 1 for 3 cycles → 3 drain beats with out_flit = 0, out_send = 1, and rr_ptr unchanged. With drain_en = 0 → out_valid stays 0.
- rst_n asserted while 2 flits are queued → all outputs go to reset values and in_ready = 4'b1111; nothing is output after release until new pushes.
- ARB_STATS_EN: 70000 grants to port 0 → grant_count[0] saturates at 16'hFFFF.
